mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : byte-serial RAM/IO port shared by instruction and data caches
// Rev 1.0
// ============================================================================
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_READ = 2'd1,
    S_D_READ  = 2'd2,
    S_D_WRITE = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  k_q;
  logic [1:0]  last_q;
  logic        ph_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic [31:0] buf_q;
  logic [31:0] wdata_q;
  logic        if_done_q;
  logic [31:0] if_data_q;
  logic        d_done_q;
  logic [31:0] d_rdata_q;

  logic        io_hold_d;
  logic        d_grant_d;
  logic        if_grant_d;
  logic [1:0]  d_last_d;
  logic        more_addr_d;
  logic [31:0] rdata_d;

  // Stores to the UART window are held back while its buffer is full.
  assign io_hold_d  = d_req & d_wr & (d_addr[17:16] == 2'b11) & io_buffer_full;
  assign d_grant_d  = d_req & ~io_hold_d & ~clear;
  assign if_grant_d = if_req & ~d_grant_d & ~clear;
  assign d_last_d   = (d_len == 2'd0) ? 2'd0 : (d_len == 2'd1) ? 2'd1 : 2'd3;
  assign more_addr_d = ({1'b0, k_q} + 3'd1) < {1'b0, last_q};

  always_comb begin
    rdata_d = buf_q;
    rdata_d[{k_q, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      k_q        <= 2'd0;
      last_q     <= 2'd0;
      ph_q       <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      buf_q      <= 32'd0;
      wdata_q    <= 32'd0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      d_done_q   <= 1'b0;
      d_rdata_q  <= 32'd0;
    end else if (rdy_in) begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mem_a_q    <= 32'd0;
          mem_dout_q <= 8'd0;
          mem_wr_q   <= 1'b0;
          if_data_q  <= 32'd0;
          d_rdata_q  <= 32'd0;
          buf_q      <= 32'd0;
          k_q        <= 2'd0;
          ph_q       <= 1'b0;
          if (d_grant_d) begin
            state_q <= d_wr ? S_D_WRITE : S_D_READ;
            mem_a_q <= d_addr;
            last_q  <= d_last_d;
            wdata_q <= d_wdata;
            if (d_wr) begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= d_wdata[7:0];
            end
          end else if (if_grant_d) begin
            state_q <= S_IF_READ;
            mem_a_q <= if_addr;
            last_q  <= 2'd3;
          end
        end
        S_IF_READ, S_D_READ: begin
          if (clear) begin
            state_q <= S_IDLE;
            mem_a_q <= 32'd0;
            k_q     <= 2'd0;
            ph_q    <= 1'b0;
          end else if (!ph_q) begin
            // First cycle only issues addresses; data lags by one cycle.
            ph_q <= 1'b1;
            if (last_q != 2'd0) mem_a_q <= mem_a_q + 32'd1;
          end else begin
            buf_q <= rdata_d;
            if (k_q == last_q) begin
              state_q <= S_IDLE;
              mem_a_q <= 32'd0;
              k_q     <= 2'd0;
              ph_q    <= 1'b0;
              if (state_q == S_IF_READ) begin
                if_done_q <= 1'b1;
                if_data_q <= rdata_d;
              end else begin
                d_done_q  <= 1'b1;
                d_rdata_q <= rdata_d;
              end
            end else begin
              k_q <= k_q + 2'd1;
              if (more_addr_d) mem_a_q <= mem_a_q + 32'd1;
            end
          end
        end
        S_D_WRITE: begin
          if (k_q == last_q) begin
            state_q    <= S_IDLE;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            k_q        <= 2'd0;
            d_done_q   <= 1'b1;
          end else begin
            k_q        <= k_q + 2'd1;
            mem_a_q    <= mem_a_q + 32'd1;
            mem_dout_q <= wdata_q[{k_q + 2'd1, 3'b000} +: 8];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy_in;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign d_done   = d_done_q;
  assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire
